// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : opcodes, functs and state encodings for the MIPS control unit
// Rev 1.0
// ============================================================================
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      ERROR  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_src_t;

endpackage
`default_nettype wire

// File: rtl/mips_alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// mips_alu_ctrl_dec : opcode/funct -> ALU control word and legality flag
// Rev 1.0
// ============================================================================
module mips_alu_ctrl_dec
   import mips_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [11:0] alu_control,
   output logic        legal
);

   always_comb begin
      alu_control = '0;
      legal       = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
               alu_control = {opcode, funct};
               legal       = 1'b1;
            end
         end
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: begin
            alu_control = {opcode, 6'b000000};
            legal       = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mips_control_fsm.sv
`default_nettype none
// ============================================================================
// mips_control_fsm : multi-cycle MIPS control unit (fetch/decode/exec/mem/wb)
// Rev 1.0
// ============================================================================
module mips_control_fsm
   import mips_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] instr,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic [11:0] alu_control,
   output logic        alu_src_imm,
   input  logic        alu_zero,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic [31:0] ir,
   output logic        err
);

   localparam logic [7:0] TO_LIMIT = 8'(ACK_TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [11:0] dec_alu;
   logic        dec_legal;
   pc_src_t     pc_sel;

   logic [5:0] op;
   logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, timed_out;

   assign op        = ir_q[31:26];
   assign is_rtype  = (op == OP_RTYPE);
   assign is_addi   = (op == OP_ADDI);
   assign is_lw     = (op == OP_LW);
   assign is_sw     = (op == OP_SW);
   assign is_beq    = (op == OP_BEQ);
   assign is_j      = (op == OP_J);
   assign timed_out = (cnt_q == TO_LIMIT);

   mips_alu_ctrl_dec u_dec (
      .opcode      (ir_q[31:26]),
      .funct       (ir_q[5:0]),
      .alu_control (dec_alu),
      .legal       (dec_legal)
   );

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         FETCH: begin
            if (timed_out) begin
               state_d = ERROR;
            end else if (imem_ack) begin
               ir_d    = instr;
               state_d = DECODE;
            end
         end
         DECODE: state_d = dec_legal ? EXEC : ERROR;
         EXEC: begin
            if (is_lw || is_sw)       state_d = MEM;
            else if (is_beq || is_j)  state_d = FETCH;
            else                      state_d = WB;
         end
         MEM: begin
            if (timed_out)     state_d = ERROR;
            else if (dmem_ack) state_d = is_lw ? WB : FETCH;
         end
         WB:      state_d = FETCH;
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase

      // Every accepted ack leaves the state, so a state change covers both clear cases.
      cnt_d = cnt_q;
      if (state_d != state_q)        cnt_d = '0;
      else if (imem_req || dmem_req) cnt_d = cnt_q + 8'd1;
   end

   always_comb begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = PC_PLUS4;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_control = '0;
      case (state_q)
         FETCH: begin
            imem_req = !timed_out;
            pc_write = !timed_out && imem_ack;
         end
         DECODE: alu_control = dec_alu;
         EXEC: begin
            alu_control = dec_alu;
            alu_src_imm = is_addi || is_lw || is_sw;
            if (is_beq) begin
               pc_sel   = PC_BRANCH;
               pc_write = alu_zero;
            end else if (is_j) begin
               pc_sel   = PC_JUMP;
               pc_write = 1'b1;
            end
         end
         MEM: begin
            alu_control = dec_alu;
            dmem_req    = !timed_out;
            dmem_we     = !timed_out && is_sw;
         end
         WB: begin
            alu_control = dec_alu;
            reg_write   = 1'b1;
            reg_dst     = is_rtype;
            mem_to_reg  = is_lw;
         end
         default: ;
      endcase
   end

   assign pc_src = pc_sel;
   assign ir     = ir_q;
   assign err    = (state_q == ERROR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire
